// File: rtl/speicher_pkg.sv
// Shared types and constants for the speicher_steuerung memory controller.
package speicher_pkg;

  localparam logic [1:0] LEERLAUF   = 2'd0;
  localparam logic [1:0] ZUGRIFF    = 2'd1;
  localparam logic [1:0] LESEWARTEN = 2'd2;
  localparam logic [1:0] ANTWORT    = 2'd3;

  typedef enum logic {
    QUELLE_BEFEHL = 1'b0,
    QUELLE_DATEN  = 1'b1
  } quelle_t;

  localparam logic [31:0] MMIO_LED_ADRESSE = 32'hFFFFFFFF;

  // Only the load/store port can reach the LED register.
  function automatic logic ist_mmio(input quelle_t quelle, input logic [31:0] adresse);
    return (quelle == QUELLE_DATEN) && (adresse == MMIO_LED_ADRESSE);
  endfunction

endpackage

// File: rtl/speicher_steuerung_if.sv
// Bus bundle between CPU ports, controller and RAM; Leds exists only with SPEICHER_LED_MMIO_EN.
interface speicher_steuerung_if #(
  parameter int WORDSIZE  = 32,
  parameter int RAMBREITE = 8
);
  logic                 BefehlAnfrage;
  logic [31:0]          BefehlAdresse;
  logic                 BefehlFertig;
  logic [WORDSIZE-1:0]  BefehlDaten;
  logic                 DatenAnfrage;
  logic                 DatenSchreiben;
  logic [31:0]          DatenAdresse;
  logic [WORDSIZE-1:0]  DatenSchreibwert;
  logic                 DatenFertig;
  logic [WORDSIZE-1:0]  DatenLesewert;
  logic                 RamSchreibenAn;
  logic [RAMBREITE-1:0] RamAdresse;
  logic [WORDSIZE-1:0]  RamDatenRein;
  logic [WORDSIZE-1:0]  RamDatenRaus;
`ifdef SPEICHER_LED_MMIO_EN
  logic [WORDSIZE-1:0]  Leds;
`endif

  modport master (
    output BefehlAnfrage, BefehlAdresse,
    input  BefehlFertig, BefehlDaten,
    output DatenAnfrage, DatenSchreiben, DatenAdresse, DatenSchreibwert,
    input  DatenFertig, DatenLesewert,
    input  RamSchreibenAn, RamAdresse, RamDatenRein,
    output RamDatenRaus
`ifdef SPEICHER_LED_MMIO_EN
    , input Leds
`endif
  );

  modport slave (
    input  BefehlAnfrage, BefehlAdresse,
    output BefehlFertig, BefehlDaten,
    input  DatenAnfrage, DatenSchreiben, DatenAdresse, DatenSchreibwert,
    output DatenFertig, DatenLesewert,
    output RamSchreibenAn, RamAdresse, RamDatenRein,
    input  RamDatenRaus
`ifdef SPEICHER_LED_MMIO_EN
    , output Leds
`endif
  );

endinterface

// File: rtl/speicher_arbiter.sv
// Fixed-priority selection between load/store and fetch requests (data wins).
module speicher_arbiter
  import speicher_pkg::*;
#(
  parameter int WORDSIZE = 32
) (
  input  logic                befehl_anfrage,
  input  logic [31:0]         befehl_adresse,
  input  logic                daten_anfrage,
  input  logic                daten_schreiben,
  input  logic [31:0]         daten_adresse,
  input  logic [WORDSIZE-1:0] daten_schreibwert,
  output logic                anfrage_s,
  output quelle_t             quelle_s,
  output logic                schreiben_s,
  output logic [31:0]         adresse_s,
  output logic [WORDSIZE-1:0] wert_s
);

  // Pick the winning requester and forward its access parameters.
  always_comb begin
    anfrage_s   = 1'b0;
    quelle_s    = QUELLE_BEFEHL;
    schreiben_s = 1'b0;
    adresse_s   = 32'h0000_0000;
    wert_s      = {WORDSIZE{1'b0}};
    if (daten_anfrage) begin
      anfrage_s   = 1'b1;
      quelle_s    = QUELLE_DATEN;
      schreiben_s = daten_schreiben;
      adresse_s   = daten_adresse;
      wert_s      = daten_schreibwert;
    end else if (befehl_anfrage) begin
      anfrage_s   = 1'b1;
      quelle_s    = QUELLE_BEFEHL;
      adresse_s   = befehl_adresse;
    end else begin
      anfrage_s   = 1'b0;
    end
  end

endmodule

// File: rtl/speicher_steuerung.sv
// Memory controller: arbitrates fetch vs load/store and sequences a 1-cycle-latency RAM.
// Optional LED register at 32'hFFFFFFFF when SPEICHER_LED_MMIO_EN is defined.
module speicher_steuerung
  import speicher_pkg::*;
#(
  parameter int WORDSIZE = 32,
  parameter int WORDS    = 256
) (
  input logic                 Clock,
  input logic                 Reset,
  speicher_steuerung_if.slave bus
);

  localparam int RAMBREITE = $clog2(WORDS);

  logic                 anfrage_s;
  quelle_t              quelle_s;
  logic                 schreiben_s;
  logic [31:0]          adresse_s;
  logic [WORDSIZE-1:0]  wert_s;
  logic                 mmio_s;
  logic                 unused_adresse_s;

  logic [1:0]           zustand_r;
  quelle_t              quelle_r;
  logic                 schreiben_r;
  logic                 befehl_fertig_r;
  logic                 daten_fertig_r;
  logic [WORDSIZE-1:0]  befehl_daten_r;
  logic [WORDSIZE-1:0]  daten_lesewert_r;
  logic                 ram_schreiben_r;
  logic [RAMBREITE-1:0] ram_adresse_r;
  logic [WORDSIZE-1:0]  ram_datenrein_r;
`ifdef SPEICHER_LED_MMIO_EN
  logic                 mmio_r;
  logic [WORDSIZE-1:0]  mmio_wert_r;
  logic [WORDSIZE-1:0]  leds_r;
`endif

  speicher_arbiter #(.WORDSIZE(WORDSIZE)) u_arbiter (
    .befehl_anfrage    (bus.BefehlAnfrage),
    .befehl_adresse    (bus.BefehlAdresse),
    .daten_anfrage     (bus.DatenAnfrage),
    .daten_schreiben   (bus.DatenSchreiben),
    .daten_adresse     (bus.DatenAdresse),
    .daten_schreibwert (bus.DatenSchreibwert),
    .anfrage_s         (anfrage_s),
    .quelle_s          (quelle_s),
    .schreiben_s       (schreiben_s),
    .adresse_s         (adresse_s),
    .wert_s            (wert_s)
  );

  // Upper address bits only matter for the LED decode; the RAM wraps.
  assign unused_adresse_s = ^adresse_s[31:RAMBREITE];

`ifdef SPEICHER_LED_MMIO_EN
  assign mmio_s = ist_mmio(quelle_s, adresse_s);
`else
  assign mmio_s = 1'b0;
`endif

  // Access sequencer: sample in LEERLAUF, drive RAM, capture read data, pulse Fertig.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand_r        <= LEERLAUF;
      quelle_r         <= QUELLE_BEFEHL;
      schreiben_r      <= 1'b0;
      befehl_fertig_r  <= 1'b0;
      daten_fertig_r   <= 1'b0;
      befehl_daten_r   <= {WORDSIZE{1'b0}};
      daten_lesewert_r <= {WORDSIZE{1'b0}};
      ram_schreiben_r  <= 1'b0;
      ram_adresse_r    <= {RAMBREITE{1'b0}};
      ram_datenrein_r  <= {WORDSIZE{1'b0}};
`ifdef SPEICHER_LED_MMIO_EN
      mmio_r           <= 1'b0;
      mmio_wert_r      <= {WORDSIZE{1'b0}};
      leds_r           <= {WORDSIZE{1'b0}};
`endif
    end else begin
      befehl_fertig_r <= 1'b0;
      daten_fertig_r  <= 1'b0;
      case (zustand_r)
        LEERLAUF: begin
          if (anfrage_s) begin
            quelle_r        <= quelle_s;
            schreiben_r     <= schreiben_s;
            ram_schreiben_r <= schreiben_s & ~mmio_s;
            // An LED access leaves the RAM address/data lines untouched.
            if (!mmio_s) begin
              ram_adresse_r   <= adresse_s[RAMBREITE-1:0];
              ram_datenrein_r <= wert_s;
            end
`ifdef SPEICHER_LED_MMIO_EN
            mmio_r      <= mmio_s;
            mmio_wert_r <= wert_s;
`endif
            zustand_r <= ZUGRIFF;
          end else begin
            ram_schreiben_r <= 1'b0;
            zustand_r       <= LEERLAUF;
          end
        end
        ZUGRIFF: begin
          ram_schreiben_r <= 1'b0;
          if (schreiben_r) begin
`ifdef SPEICHER_LED_MMIO_EN
            if (mmio_r) begin
              leds_r <= mmio_wert_r;
            end
`endif
            if (quelle_r == QUELLE_DATEN) begin
              daten_fertig_r <= 1'b1;
            end else begin
              befehl_fertig_r <= 1'b1;
            end
            zustand_r <= ANTWORT;
          end else begin
            zustand_r <= LESEWARTEN;
          end
        end
        LESEWARTEN: begin
          if (quelle_r == QUELLE_DATEN) begin
`ifdef SPEICHER_LED_MMIO_EN
            daten_lesewert_r <= mmio_r ? leds_r : bus.RamDatenRaus;
`else
            daten_lesewert_r <= bus.RamDatenRaus;
`endif
            daten_fertig_r <= 1'b1;
          end else begin
            befehl_daten_r  <= bus.RamDatenRaus;
            befehl_fertig_r <= 1'b1;
          end
          zustand_r <= ANTWORT;
        end
        ANTWORT: begin
          zustand_r <= LEERLAUF;
        end
        default: begin
          ram_schreiben_r <= 1'b0;
          zustand_r       <= LEERLAUF;
        end
      endcase
    end
  end

  assign bus.BefehlFertig   = befehl_fertig_r;
  assign bus.BefehlDaten    = befehl_daten_r;
  assign bus.DatenFertig    = daten_fertig_r;
  assign bus.DatenLesewert  = daten_lesewert_r;
  assign bus.RamSchreibenAn = ram_schreiben_r;
  assign bus.RamAdresse     = ram_adresse_r;
  assign bus.RamDatenRein   = ram_datenrein_r;
`ifdef SPEICHER_LED_MMIO_EN
  assign bus.Leds           = leds_r;
`endif

endmodule

// File: doc/speicher_steuerung.md
Name: speicher_steuerung

Overview:
- Memory controller sitting directly upstream of the single-port synchronous word RAM (registered read data, 1-cycle read latency, write-or-read per cycle).
- Arbitrates between the processor's instruction-fetch port and load/store port.
- Sequences RAM accesses with a small FSM and returns read data through a request/done handshake.
- Owns the RAM's SchreibenAn, Adresse and DatenRein; consumes DatenRaus.

Parameters:
- WORDSIZE, 32, data word width in bits; must match the RAM.
- WORDS, 256, RAM depth in words; RAM address width RAMBREITE = $clog2(WORDS).

Ports:
- Clock  input  1  single system clock; all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- BefehlAnfrage  input  1  fetch request; held high until BefehlFertig.
- BefehlAdresse  input  32  fetch word address.
- BefehlFertig  output  1  one-cycle pulse; BefehlDaten valid in the same cycle.
- BefehlDaten  output  WORDSIZE  fetched instruction word.
- DatenAnfrage  input  1  load/store request; held high until DatenFertig.
- DatenSchreiben  input  1  1 = store, 0 = load; stable while DatenAnfrage is high.
- DatenAdresse  input  32  load/store word address.
- DatenSchreibwert  input  WORDSIZE  store data.
- DatenFertig  output  1  one-cycle pulse; DatenLesewert valid in the same cycle for loads.
- DatenLesewert  output  WORDSIZE  load result.
- RamSchreibenAn  output  1  to RAM SchreibenAn.
- RamAdresse  output  RAMBREITE  to RAM Adresse.
- RamDatenRein  output  WORDSIZE  to RAM DatenRein.
- RamDatenRaus  input  WORDSIZE  from RAM DatenRaus.

Behaviour:
- All outputs are registered.
- Reset state: state = LEERLAUF; all Fertig = 0; RamSchreibenAn = 0; RamAdresse, RamDatenRein, BefehlDaten and DatenLesewert = 0.
- Reset mid-access aborts the access. No Fertig pulse is issued, and the requester must re-request.
- FSM states: LEERLAUF, ZUGRIFF, LESEWARTEN, ANTWORT.
- LEERLAUF:
  - Samples requests.
  - Priority: DatenAnfrage over BefehlAnfrage.
  - Latches the winner: source, write flag, address[RAMBREITE-1:0], store data.
  - Moves to ZUGRIFF and registers the RAM signals. RamSchreibenAn = 1 only for a store.
  - With no request, stays in LEERLAUF with RamSchreibenAn = 0.
- ZUGRIFF:
  - RAM performs the access at this clock edge.
  - Store: next state ANTWORT, RamSchreibenAn cleared.
  - Load or fetch: next state LESEWARTEN.
- LESEWARTEN: RamDatenRaus is valid. It is captured into the winner's data output register. Next state ANTWORT.
- ANTWORT:
  - The winner's Fertig is 1 for exactly one cycle. Next state LEERLAUF.
  - Requests are re-sampled only in LEERLAUF, so a requester that drops its request on Fertig is never served twice.
- Latency from the sampling edge to the Fertig cycle: store 2 cycles, load/fetch 3 cycles.
- Back-to-back requests lose one idle cycle; the next sample is taken in LEERLAUF.
- Simultaneous fetch and data requests: the data access is served first. The fetch is served on the next LEERLAUF; no starvation, since the CPU stalls on a load/store.
- Address wrap: upper address bits [31:RAMBREITE] are ignored. For example, address WORDS aliases address 0.
- BefehlDaten and DatenLesewert hold their last value until overwritten.
- RamSchreibenAn is never 1 outside ZUGRIFF-for-store.

Optional Feature:
- Macro: SPEICHER_LED_MMIO_EN.
- When defined:
  - Adds output Leds (WORDSIZE), reset 0.
  - A store to DatenAdresse 32'hFFFFFFFF writes Leds and never asserts RamSchreibenAn.
  - A load from that address returns Leds.
  - Both skip the RAM and take the same state path and latency as normal accesses; the RAM port is held idle.
- When undefined: no Leds port, and 32'hFFFFFFFF aliases RAM word WORDS-1 per the wrap rule.

Decomposition:
- Shared package speicher_pkg:
  - FSM state encoding: LEERLAUF, ZUGRIFF, LESEWARTEN, ANTWORT.
  - Source enum: QUELLE_BEFEHL, QUELLE_DATEN.
  - Constant MMIO_LED_ADRESSE = 32'hFFFFFFFF.
- One sub-module is natural: speicher_arbiter, combinational fixed-priority selection of source, address, data and write flag. The FSM stays in speicher_steuerung.
- The bench instantiates the real RAM behind the controller.

Test Plan:
- Reset: assert Reset for 2 cycles during a pending load -> all outputs 0, state LEERLAUF, no Fertig pulse after release.
- Fetch: RAM preloaded word 0 = 32'h8020FFFF; BefehlAnfrage with address 0 -> BefehlFertig exactly 3 cycles after the sampling edge, BefehlDaten = 32'h8020FFFF, DatenFertig stays 0.
- Store then load: store 32'hFFFFFFFF to address 5 -> DatenFertig after 2 cycles, RamSchreibenAn high exactly 1 cycle; then load from address 5 -> DatenLesewert = 32'hFFFFFFFF.
- Contention: BefehlAnfrage (address 1) and DatenAnfrage (load, address 2) raised in the same cycle -> DatenFertig first, then BefehlFertig 4 cycles later, each with the correct word.
- Wrap: store 32'h12345678 to address 256 (WORDS = 256) -> load from address 0 returns 32'h12345678.
- MMIO (SPEICHER_LED_MMIO_EN defined): store 32'h000000AA to 32'hFFFFFFFF -> Leds = 32'hAA, RamSchreibenAn never asserted, RAM word 255 unchanged; a load from that address returns 32'hAA.
